// File: rtl/ps2_keycode_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keycode_rx
// Purpose  : PS/2 keyboard receiver producing keycode/press levels with
//            F0/E0 prefix handling. Optional: PS2_TYPEMATIC_FILTER_EN.
// Revision : 1.0
// ============================================================================
module ps2_keycode_rx #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk_clk,
   input  logic       reset_reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keycode_export,
   output logic       press_export,
   output logic       extended,
   output logic       code_valid,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic                   clk_prev_q;

   state_t        state_q;
   logic [2:0]    bitcnt_q;
   logic [7:0]    shreg_q;
   logic          parity_q;
   logic [TW-1:0] tmo_cnt_q;
   logic          ext_pend_q;
   logic          brk_pend_q;
   logic [7:0]    keycode_q;
   logic          press_q;
   logic          ext_q;
   logic          valid_q;
   logic          err_q;

   logic clk_s;
   logic data_s;
   logic fall_edge;
   logic byte_ok;
   logic typematic_rep;

   assign clk_s     = clk_sync_q[SYNC_STAGES-1];
   assign data_s    = data_sync_q[SYNC_STAGES-1];
   assign fall_edge = clk_prev_q & ~clk_s;
   // Odd parity over data+parity and a high stop bit.
   assign byte_ok   = data_s & ((^shreg_q) ^ parity_q);

`ifdef PS2_TYPEMATIC_FILTER_EN
   assign typematic_rep = press_q && (shreg_q == keycode_q) && (ext_pend_q == ext_q);
`else
   assign typematic_rep = 1'b0;
`endif

   // Sync chains reset low so a high idle line never looks like a falling edge.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         clk_sync_q  <= '0;
         data_sync_q <= '0;
         clk_prev_q  <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
         clk_prev_q  <= clk_s;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q    <= ST_IDLE;
         bitcnt_q   <= 3'd0;
         shreg_q    <= 8'h00;
         parity_q   <= 1'b0;
         tmo_cnt_q  <= '0;
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
         keycode_q  <= 8'h00;
         press_q    <= 1'b0;
         ext_q      <= 1'b0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (fall_edge) begin
            tmo_cnt_q <= '0;
            case (state_q)
               ST_IDLE: begin
                  if (!data_s) begin
                     state_q  <= ST_DATA;
                     bitcnt_q <= 3'd0;
                  end
               end
               ST_DATA: begin
                  shreg_q  <= {data_s, shreg_q[7:1]};
                  bitcnt_q <= bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) begin
                     state_q <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  parity_q <= data_s;
                  state_q  <= ST_STOP;
               end
               ST_STOP: begin
                  state_q <= ST_IDLE;
                  if (byte_ok) begin
                     if (shreg_q == 8'hE0) begin
                        ext_pend_q <= 1'b1;
                     end else if (shreg_q == 8'hF0) begin
                        brk_pend_q <= 1'b1;
                     end else begin
                        ext_pend_q <= 1'b0;
                        brk_pend_q <= 1'b0;
                        if (!brk_pend_q) begin
                           if (!typematic_rep) begin
                              keycode_q <= shreg_q;
                              press_q   <= 1'b1;
                              ext_q     <= ext_pend_q;
                              valid_q   <= 1'b1;
                           end
                        end else if ((shreg_q == keycode_q) && (ext_pend_q == ext_q)) begin
                           press_q <= 1'b0;
                           valid_q <= 1'b1;
                        end
                     end
                  end else begin
                     err_q      <= 1'b1;
                     ext_pend_q <= 1'b0;
                     brk_pend_q <= 1'b0;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end else if (state_q != ST_IDLE) begin
            // Stalled frame: abandon silently, prefixes survive.
            if (tmo_cnt_q == TMO_LAST) begin
               state_q   <= ST_IDLE;
               tmo_cnt_q <= '0;
               bitcnt_q  <= 3'd0;
            end else begin
               tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
         end
      end
   end

   assign keycode_export = keycode_q;
   assign press_export   = press_q;
   assign extended       = ext_q;
   assign code_valid     = valid_q;
   assign frame_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keycode_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keycode_rx
// Purpose  : Directed bench for ps2_keycode_rx with hand-computed results.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_keycode_rx;

   localparam int TMO  = 2000;
   localparam int HALF = 20;

   logic       clk_clk     = 1'b0;
   logic       reset_reset = 1'b1;
   logic       ps2_clk     = 1'b1;
   logic       ps2_data    = 1'b1;
   logic [7:0] keycode_export;
   logic       press_export;
   logic       extended;
   logic       code_valid;
   logic       frame_err;

   int n_checks = 0;
   int n_errors = 0;
   int n_valid  = 0;
   int n_ferr   = 0;
   int n_both   = 0;
   int v0       = 0;
   int e0       = 0;

   ps2_keycode_rx #(
      .TIMEOUT_CYCLES (TMO),
      .SYNC_STAGES    (2)
   ) dut (
      .clk_clk        (clk_clk),
      .reset_reset    (reset_reset),
      .ps2_clk        (ps2_clk),
      .ps2_data       (ps2_data),
      .keycode_export (keycode_export),
      .press_export   (press_export),
      .extended       (extended),
      .code_valid     (code_valid),
      .frame_err      (frame_err)
   );

   always #10 clk_clk = ~clk_clk;

   always @(negedge clk_clk) begin
      if (code_valid) n_valid++;
      if (frame_err) n_ferr++;
      if (code_valid && frame_err) n_both++;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_clk);
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_cyc(HALF / 2);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
      wait_cyc(HALF / 2);
   endtask

   // Parity bit is odd parity (~^byte), optionally inverted to force an error.
   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ par_flip);
      send_bit(stop);
      ps2_data = 1'b1;
      wait_cyc(10);
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits);
      send_bit(1'b0);
      for (int i = 0; i < nbits; i++) send_bit(b[i]);
      ps2_data = 1'b1;
   endtask

   task automatic mark();
      v0 = n_valid;
      e0 = n_ferr;
   endtask

   task automatic verify(input string tag, input logic [7:0] key, input logic press,
                         input logic ext, input int dv, input int de);
      check_eq({tag, "_key"},   32'(keycode_export), 32'(key));
      check_eq({tag, "_press"}, 32'(press_export),   32'(press));
      check_eq({tag, "_ext"},   32'(extended),       32'(ext));
      check_eq({tag, "_nvalid"}, 32'(n_valid - v0),  32'(dv));
      check_eq({tag, "_nferr"},  32'(n_ferr - e0),   32'(de));
   endtask

   initial begin
      wait_cyc(5);
      check_eq("rst_key",   32'(keycode_export), 32'h00);
      check_eq("rst_press", 32'(press_export),   32'h0);
      check_eq("rst_ext",   32'(extended),       32'h0);
      check_eq("rst_valid", 32'(code_valid),     32'h0);
      check_eq("rst_ferr",  32'(frame_err),      32'h0);
      reset_reset = 1'b0;
      wait_cyc(5);

      mark(); send_frame(8'h29, 1'b0, 1'b1);
      verify("make29", 8'h29, 1'b1, 1'b0, 1, 0);

      mark(); send_frame(8'hF0, 1'b0, 1'b1); send_frame(8'h29, 1'b0, 1'b1);
      verify("brk29", 8'h29, 1'b0, 1'b0, 1, 0);

      mark(); send_frame(8'hF0, 1'b0, 1'b1); send_frame(8'h1C, 1'b0, 1'b1);
      verify("brk1C_nomatch", 8'h29, 1'b0, 1'b0, 0, 0);

      mark(); send_frame(8'hE0, 1'b0, 1'b1); send_frame(8'h75, 1'b0, 1'b1);
      verify("make_e075", 8'h75, 1'b1, 1'b1, 1, 0);

      mark(); send_frame(8'hE0, 1'b0, 1'b1); send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h75, 1'b0, 1'b1);
      verify("brk_e075", 8'h75, 1'b0, 1'b1, 1, 0);

      mark(); send_frame(8'h29, 1'b1, 1'b1);
      verify("bad_parity", 8'h75, 1'b0, 1'b1, 0, 1);

      mark(); send_frame(8'h29, 1'b0, 1'b0);
      verify("bad_stop", 8'h75, 1'b0, 1'b1, 0, 1);

      // Prefixes pending before an errored frame must be discarded.
      mark(); send_frame(8'hF0, 1'b0, 1'b1); send_frame(8'h29, 1'b1, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b1);
      verify("err_clears_brk", 8'h1C, 1'b1, 1'b0, 1, 1);

      mark(); send_frame(8'h6B, 1'b0, 1'b1);
      verify("make6B", 8'h6B, 1'b1, 1'b0, 1, 0);

      // Stall mid-frame past the timeout; E0 sent beforehand must survive it.
      mark(); send_frame(8'hE0, 1'b0, 1'b1);
      send_partial(8'h5A, 4);
      wait_cyc(TMO + 100);
      verify("timeout_silent", 8'h6B, 1'b1, 1'b0, 0, 0);
      mark(); send_frame(8'h1C, 1'b0, 1'b1);
      verify("after_timeout", 8'h1C, 1'b1, 1'b1, 1, 0);

      send_partial(8'h29, 3);
      reset_reset = 1'b1;
      wait_cyc(3);
      mark();
      verify("mid_reset", 8'h00, 1'b0, 1'b0, 0, 0);
      reset_reset = 1'b0;
      wait_cyc(5);
      mark(); send_frame(8'h5A, 1'b0, 1'b1);
      verify("post_reset", 8'h5A, 1'b1, 1'b0, 1, 0);

      mark();
      send_frame(8'h29, 1'b0, 1'b1);
      send_frame(8'h29, 1'b0, 1'b1);
      send_frame(8'h29, 1'b0, 1'b1);
`ifdef PS2_TYPEMATIC_FILTER_EN
      verify("typematic", 8'h29, 1'b1, 1'b0, 1, 0);
`else
      verify("typematic", 8'h29, 1'b1, 1'b0, 3, 0);
`endif

      check_eq("pulse_exclusive", 32'(n_both), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
